// File: rtl/eda_img_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// eda_imreg_pkg
// Shared definitions for the regional-max image pipeline.
//   - scan_state_t : sequencer states (IDLE, LOAD, SCAN, DONE)
//   - NB_*         : bit positions of each neighbour inside the 8-bit border
//                    mask, shared with the compare stage so both sides agree
//                    on the mask layout.
// -----------------------------------------------------------------------------
package eda_imreg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } scan_state_t;

  localparam int NB_UPLEFT    = 7;
  localparam int NB_UP        = 6;
  localparam int NB_UPRIGHT   = 5;
  localparam int NB_LEFT      = 4;
  localparam int NB_RIGHT     = 3;
  localparam int NB_DOWNLEFT  = 2;
  localparam int NB_DOWN      = 1;
  localparam int NB_DOWNRIGHT = 0;

endpackage

// File: rtl/eda_img_scan_ctrl_border_mask.sv
// -----------------------------------------------------------------------------
// eda_border_mask
// Combinational border-validity mask for a 3x3 window centred at (row, col)
// in an M x N frame. A bit is set when that neighbour lies inside the frame.
// Only equality compares against the first/last row and column are used, so
// no division or modulo is needed.
//
// Ports:
//   row  : row of the window centre
//   col  : column of the window centre
//   mask : neighbour mask, bit positions given by NB_* in eda_imreg_pkg
// -----------------------------------------------------------------------------
module eda_border_mask #(
  parameter int M         = 16,
  parameter int N         = 16,
  parameter int ROW_WIDTH = (N > 1) ? $clog2(N) : 1,
  parameter int COL_WIDTH = (M > 1) ? $clog2(M) : 1
) (
  input  logic [ROW_WIDTH-1:0] row,
  input  logic [COL_WIDTH-1:0] col,
  output logic [7:0]           mask
);

  import eda_imreg_pkg::*;

  localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(N - 1);
  localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(M - 1);

  logic has_up;
  logic has_down;
  logic has_left;
  logic has_right;

  // With M=1 or N=1 the first and last index coincide, so both directions
  // on that axis correctly collapse to "outside the frame".
  always_comb begin
    has_up    = (row != '0);
    has_down  = (row != ROW_LAST);
    has_left  = (col != '0);
    has_right = (col != COL_LAST);

    mask               = '0;
    mask[NB_UPLEFT]    = has_up   & has_left;
    mask[NB_UP]        = has_up;
    mask[NB_UPRIGHT]   = has_up   & has_right;
    mask[NB_LEFT]      = has_left;
    mask[NB_RIGHT]     = has_right;
    mask[NB_DOWNLEFT]  = has_down & has_left;
    mask[NB_DOWN]      = has_down;
    mask[NB_DOWNRIGHT] = has_down & has_right;
  end

endmodule

// File: rtl/eda_img_scan_ctrl.sv
// -----------------------------------------------------------------------------
// eda_img_scan_ctrl
// Sequencer for the image window RAM of the regional-max pipeline. Loads one
// M*N frame from a valid/ready pixel stream into the RAM in raster order,
// then sweeps the RAM centre address across every pixel and offers each 3x3
// window downstream with a valid/ready handshake plus a border mask.
//
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : begin a frame (only honoured in IDLE)
//   abort               : synchronous return to IDLE from any state
//   busy                : high while loading or scanning
//   done                : one-cycle pulse after the last window is accepted
//   pix_valid/pix_ready : input pixel handshake, pix_data in raster order
//   ram_write_en        : RAM write strobe (same-cycle as the handshake)
//   ram_wr_addr         : RAM write address
//   ram_pixel_in        : RAM write data
//   ram_center_addr     : RAM window centre address
//   win_valid/win_ready : window handshake toward the compare stage
//   win_row, win_col    : coordinates of the current centre
//   neigh_valid         : border mask aligned with ram_center_addr
// -----------------------------------------------------------------------------
module eda_img_scan_ctrl #(
  parameter int M           = 16,
  parameter int N           = 16,
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = (M * N > 1) ? $clog2(M * N) : 1,
  parameter int ROW_WIDTH   = (N > 1) ? $clog2(N) : 1,
  parameter int COL_WIDTH   = (M > 1) ? $clog2(M) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [PIXEL_WIDTH-1:0] pix_data,
  output logic                   ram_write_en,
  output logic [ADDR_WIDTH-1:0]  ram_wr_addr,
  output logic [PIXEL_WIDTH-1:0] ram_pixel_in,
  output logic [ADDR_WIDTH-1:0]  ram_center_addr,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [ROW_WIDTH-1:0]   win_row,
  output logic [COL_WIDTH-1:0]   win_col,
  output logic [7:0]             neigh_valid
);

  import eda_imreg_pkg::*;

  // Explicit last-index compares keep non-power-of-2 frames from wrapping.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(M * N - 1);
  localparam logic [COL_WIDTH-1:0]  COL_LAST  = COL_WIDTH'(M - 1);

  scan_state_t           state;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] center_cnt;
  logic [ROW_WIDTH-1:0]  row_nxt;
  logic [COL_WIDTH-1:0]  col_nxt;
  logic [7:0]            mask_nxt;
  logic [7:0]            mask_origin;
  logic                  pix_hs;
  logic                  win_hs;

  // pix_ready and win_valid are registered copies of "state is LOAD/SCAN",
  // so they double as cheap state decodes for the handshakes.
  assign pix_hs = pix_valid & pix_ready;
  assign win_hs = win_valid & win_ready;

  // The write path is deliberately combinational so the RAM captures the
  // pixel on the same edge that completes the handshake. A pixel offered
  // together with abort still lands in RAM; only the count is dropped.
  assign ram_write_en    = pix_hs;
  assign ram_wr_addr     = wr_cnt;
  assign ram_pixel_in    = pix_data;
  assign ram_center_addr = center_cnt;

  // Raster step from the current centre; only used while scanning.
  always_comb begin
    if (win_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = win_row + ROW_WIDTH'(1);
    end else begin
      col_nxt = win_col + COL_WIDTH'(1);
      row_nxt = win_row;
    end
  end

  // Mask for the next centre, registered on acceptance so neigh_valid stays
  // aligned with ram_center_addr and holds during backpressure.
  eda_border_mask #(
    .M         (M),
    .N         (N),
    .ROW_WIDTH (ROW_WIDTH),
    .COL_WIDTH (COL_WIDTH)
  ) u_mask_next (
    .row  (row_nxt),
    .col  (col_nxt),
    .mask (mask_nxt)
  );

  // Mask of the first window, loaded when the scan begins.
  eda_border_mask #(
    .M         (M),
    .N         (N),
    .ROW_WIDTH (ROW_WIDTH),
    .COL_WIDTH (COL_WIDTH)
  ) u_mask_origin (
    .row  ('0),
    .col  ('0),
    .mask (mask_origin)
  );

  // Sequencer. abort outranks start and both handshakes; all status outputs
  // are registered here alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      center_cnt  <= '0;
      win_row     <= '0;
      win_col     <= '0;
      neigh_valid <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pix_ready   <= 1'b0;
      win_valid   <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      center_cnt  <= '0;
      win_row     <= '0;
      win_col     <= '0;
      neigh_valid <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pix_ready   <= 1'b0;
      win_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= LOAD;
            wr_cnt    <= '0;
            busy      <= 1'b1;
            pix_ready <= 1'b1;
          end
        end

        LOAD: begin
          if (pix_hs) begin
            if (wr_cnt == LAST_ADDR) begin
              state       <= SCAN;
              wr_cnt      <= '0;
              pix_ready   <= 1'b0;
              win_valid   <= 1'b1;
              center_cnt  <= '0;
              win_row     <= '0;
              win_col     <= '0;
              neigh_valid <= mask_origin;
            end else begin
              wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
            end
          end
        end

        SCAN: begin
          if (win_hs) begin
            if (center_cnt == LAST_ADDR) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              win_valid   <= 1'b0;
              center_cnt  <= '0;
              win_row     <= '0;
              win_col     <= '0;
              neigh_valid <= '0;
            end else begin
              center_cnt  <= center_cnt + ADDR_WIDTH'(1);
              win_row     <= row_nxt;
              win_col     <= col_nxt;
              neigh_valid <= mask_nxt;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eda_img_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eda_img_scan_ctrl
// Self-checking bench for eda_img_scan_ctrl with a 4x3 frame. Expected
// addresses, coordinates and masks come from plain arithmetic on the pixel
// index (idx / M, idx % M) and the border rules.
// -----------------------------------------------------------------------------
module tb_eda_img_scan_ctrl;

  localparam int M  = 4;
  localparam int N  = 3;
  localparam int PW = 8;
  localparam int AW = $clog2(M * N);
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(M);

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          pix_valid;
  logic          pix_ready;
  logic [PW-1:0] pix_data;
  logic          ram_write_en;
  logic [AW-1:0] ram_wr_addr;
  logic [PW-1:0] ram_pixel_in;
  logic [AW-1:0] ram_center_addr;
  logic          win_valid;
  logic          win_ready;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic [7:0]    neigh_valid;

  int tests = 0;
  int fails = 0;

  eda_img_scan_ctrl #(
    .M           (M),
    .N           (N),
    .PIXEL_WIDTH (PW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .busy            (busy),
    .done            (done),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_data        (pix_data),
    .ram_write_en    (ram_write_en),
    .ram_wr_addr     (ram_wr_addr),
    .ram_pixel_in    (ram_pixel_in),
    .ram_center_addr (ram_center_addr),
    .win_valid       (win_valid),
    .win_ready       (win_ready),
    .win_row         (win_row),
    .win_col         (win_col),
    .neigh_valid     (neigh_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Border rules evaluated directly on frame coordinates.
  function automatic logic [7:0] model_mask(input int idx);
    int r;
    int c;
    logic up, dn, lf, rt;
    r  = idx / M;
    c  = idx % M;
    up = (r > 0);
    dn = (r < N - 1);
    lf = (c > 0);
    rt = (c < M - 1);
    return {up & lf, up, up & rt, lf, rt, dn & lf, dn, dn & rt};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later,
  // well clear of the next rising edge.
  task automatic applyStimulus(input logic st, input logic ab, input logic pv,
                               input logic [PW-1:0] pd, input logic wr);
    @(negedge clk);
    start     = st;
    abort     = ab;
    pix_valid = pv;
    pix_data  = pd;
    win_ready = wr;
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},      busy,            0);
    checkOutput({tag, "_done"},      done,            0);
    checkOutput({tag, "_pix_ready"}, pix_ready,       0);
    checkOutput({tag, "_win_valid"}, win_valid,       0);
    checkOutput({tag, "_wr_addr"},   ram_wr_addr,     0);
    checkOutput({tag, "_center"},    ram_center_addr, 0);
    checkOutput({tag, "_row"},       win_row,         0);
    checkOutput({tag, "_col"},       win_col,         0);
    checkOutput({tag, "_mask"},      neigh_valid,     0);
  endtask

  // Feeds pixels until `count` handshakes have happened.
  task automatic loadFrame(input bit rand_valid, input int count,
                           input logic hold_start);
    int   cnt = 0;
    int   cyc = 0;
    logic pv;
    logic [PW-1:0] pd;
    while (cnt < count && cyc < 200) begin
      pv = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      pd = PW'($urandom_range(0, 255));
      applyStimulus(hold_start, 1'b0, pv, pd, 1'b0);
      checkOutput("load_pix_ready", pix_ready,    1);
      checkOutput("load_busy",      busy,         1);
      checkOutput("load_win_valid", win_valid,    0);
      checkOutput("load_write_en",  ram_write_en, pv);
      if (pv) begin
        checkOutput("load_wr_addr", ram_wr_addr,  cnt);
        checkOutput("load_wr_data", ram_pixel_in, pd);
        cnt++;
      end
      cyc++;
    end
    checkOutput("load_budget", cnt, count);
  endtask

  // Accepts windows until centre `stop_idx` is reached; a stall of three
  // cycles is forced on the first visit to `stall_idx`.
  task automatic scanFrame(input bit rand_ready, input int stall_idx,
                           input int stop_idx);
    int   idx   = 0;
    int   cyc   = 0;
    int   stall = 0;
    logic wr;
    while (idx < stop_idx && cyc < 500) begin
      wr = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (idx == stall_idx && stall < 3) begin
        wr = 1'b0;
        stall++;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, '0, wr);
      checkOutput("scan_win_valid", win_valid,       1);
      checkOutput("scan_busy",      busy,            1);
      checkOutput("scan_done",      done,            0);
      checkOutput("scan_pix_ready", pix_ready,       0);
      checkOutput("scan_center",    ram_center_addr, idx);
      checkOutput("scan_row",       win_row,         idx / M);
      checkOutput("scan_col",       win_col,         idx % M);
      checkOutput("scan_mask",      neigh_valid,     model_mask(idx));
      if (idx == 0)  checkOutput("mask_c0",  neigh_valid, 8'b0000_1011);
      if (idx == 4)  checkOutput("mask_c4",  neigh_valid, 8'b0110_1011);
      if (idx == 5)  checkOutput("mask_c5",  neigh_valid, 8'hFF);
      if (idx == 11) checkOutput("mask_c11", neigh_valid, 8'b1101_0000);
      if (wr) idx++;
      cyc++;
    end
    checkOutput("scan_budget", idx, stop_idx);
  endtask

  task automatic checkDone();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("done_pulse",     done,        1);
    checkOutput("done_win_valid", win_valid,   0);
    checkOutput("done_busy",      busy,        0);
    checkOutput("done_mask",      neigh_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("done_single",    done,        0);
    checkOutput("idle_busy",      busy,        0);
    checkOutput("idle_pix_ready", pix_ready,   0);
  endtask

  task automatic startFrame();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("start_busy", busy, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    win_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkIdleOutputs("reset");
    checkOutput("reset_write_en", ram_write_en, 0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkIdleOutputs("idle");

    // Frame 1: back-to-back pixels and windows.
    $display("[TB] frame 1: contiguous load and scan");
    startFrame();
    loadFrame(1'b0, M * N, 1'b0);
    scanFrame(1'b0, -1, M * N);
    checkDone();

    // Frame 2: input bubbles, start held high, random backpressure and a
    // three-cycle stall at centre 6.
    $display("[TB] frame 2: bubbles and backpressure");
    startFrame();
    loadFrame(1'b1, M * N, 1'b1);
    scanFrame(1'b1, 6, M * N);
    checkDone();

    // Frame 3: abort while centre 5 is presented.
    $display("[TB] frame 3: abort during scan");
    startFrame();
    loadFrame(1'b0, M * N, 1'b0);
    scanFrame(1'b1, -1, 5);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("abort_center_pre", ram_center_addr, 5);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkIdleOutputs("abort_scan");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("abort_no_done", done, 0);

    // Frame 4: abort in LOAD with a pixel on the bus, then a clean reload.
    $display("[TB] frame 4: abort during load");
    startFrame();
    loadFrame(1'b0, 3, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0);
    checkOutput("abort_load_write_en", ram_write_en, 1);
    checkOutput("abort_load_wr_addr",  ram_wr_addr,  3);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    checkIdleOutputs("abort_load");
    checkOutput("abort_load_idle_we", ram_write_en, 0);
    startFrame();
    loadFrame(1'b1, M * N, 1'b0);
    scanFrame(1'b1, -1, M * N);
    checkDone();

    // Frame 5: asynchronous reset after seven pixels.
    $display("[TB] frame 5: async reset during load");
    startFrame();
    loadFrame(1'b1, 7, 1'b0);
    @(negedge clk);
    pix_valid = 1'b1;
    start     = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    checkIdleOutputs("async_reset");
    checkOutput("async_reset_we", ram_write_en, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0);
    checkOutput("reset_start_ignored", busy, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0);
    checkOutput("reset_start_ignored2", pix_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkIdleOutputs("post_reset");
    startFrame();
    loadFrame(1'b1, M * N, 1'b0);
    scanFrame(1'b1, 2, M * N);
    checkDone();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
